axi_magphase_gain_multi: RTL and testbench
==========================================

// Module: axi_magphase_gain_multi
// PURPOSE
//  Multi-channel, parametrised mag/phase gain stage for RFNoC compute engines; sits after complex_to_magphase.
//  Input beats are TDM channels. Per channel: magnitude scaled with round and saturate; phase scaled, offset, wrapped modulo 2^WIDTH.
//  Per-channel gains, offsets and bypass are set over the settings bus. They take effect only at packet boundaries.
//  Output is fully pipelined: one beat per clock, fixed latency.
// PARAMETERS
//  WIDTH       16   bits per mag/phase component (two's complement)
//  GAIN_WIDTH  16   signed gain width
//  GAIN_FRAC   14   gain fractional bits; unity = 1<<GAIN_FRAC
//  NUM_CHAN    4    TDM channels per packet cycle (>=1)
//  SR_BASE     192  first settings address used
// PORTS
//  clk        in   1           compute-engine clock
//  reset_n    in   1           synchronous, active-low reset
//  set_stb    in   1           settings write strobe
//  set_addr   in   8           settings address
//  set_data   in   32          settings data
//  i_tdata    in   2*WIDTH     {mag, phase}; mag in upper half
//  i_tlast    in   1           end of packet
//  i_tvalid   in   1           input valid
//  i_tready   out  1           input ready
//  o_tdata    out  2*WIDTH     {mag_out, phase_out}
//  o_tlast    out  1           end of packet, delayed with its beat
//  o_tvalid   out  1           output valid
//  o_tready   in   1           output ready
//  o_chan     out  clog2(NUM_CHAN) (min 1)  channel index of the current output beat
//  sat_count  out  16          magnitude saturation counter; saturates at 0xFFFF
// BEHAVIOUR
//  Settings map:
//   - SR_BASE+2c: mag_gain[c] = data[GAIN_WIDTH-1:0]
//   - SR_BASE+2c+1: phase_gain[c] = data[15:0], phase_off[c] = data[31:16], sign-extended/truncated to WIDTH
//   - SR_BASE+2*NUM_CHAN: ctrl; bit0 = bypass, bit1 = clear sat_count (self-clearing pulse, not stored)
//   - Other addresses are ignored.
//  Reset (reset_n=0 at a clk edge):
//   - Gains = unity, offsets = 0, bypass = 0.
//   - Shadow copies = same defaults.
//   - Channel counter = 0, all pipeline valids = 0 (in-flight beats discarded).
//   - Outputs: o_tvalid=0, o_tdata=0, o_tlast=0, o_chan=0, sat_count=0.
//   - i_tready=1 from the first cycle after reset deasserts.
//  Handshake:
//   - en = ~o_tvalid | o_tready; i_tready = en; every stage advances only when en=1.
//   - Bubbles propagate as valid=0. No combinational path from i_tvalid to o_tvalid.
//   - o_tdata/o_tlast/o_chan are held stable while o_tvalid=1 and o_tready=0.
//  Latency: accepted beat appears on o_* exactly 3 en-cycles later (3 clocks with o_tready held high).
//  Pipeline:
//   - S1: products (WIDTH+GAIN_WIDTH bits, signed) for mag and phase.
//   - S2: round half-up (add 1<<(GAIN_FRAC-1), arithmetic shift right by GAIN_FRAC), then add phase_off.
//   - S3: mag saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; phase keeps low WIDTH bits (wrap, never saturates).
//  Bypass: o_tdata = i_tdata delayed by the same 3 stages; sat_count does not change.
//  Channel counter:
//   - Increments on each accepted input beat; wraps NUM_CHAN-1 -> 0.
//   - Forced to 0 after an accepted beat with i_tlast=1.
//   - The counter value travels with the beat to o_chan.
//  Shadow update:
//   - On acceptance of the first beat of a packet (first beat after reset or after a tlast beat), all gains, offsets and bypass are copied to shadow registers.
//   - The datapath uses only shadow values.
//   - A settings write in the same cycle as that copy is not included; it applies from the next packet.
//  sat_count:
//   - +1 per output handshake whose mag saturated (non-bypass); holds at 0xFFFF.
//   - Clear and increment in the same cycle -> 0.
//  NUM_CHAN=1: counter is constant 0; o_chan is 1 bit, always 0.
// TESTING
//  1. Defaults, 1 chan, mag=1000, phase=-500 -> out {1000,-500} after 3 clks; o_tlast aligned.
//  2. mag_gain[0]=0x6000: mag 1000 -> 1500; mag 30000 -> 32767, sat_count=1; mag 3 with gain 0x2000 -> 2; mag -3 -> -1.
//  3. phase_gain=0x4000, phase_off=20000, phase 20000 -> 0x9C40 (-25536); sat_count unchanged.
//  4. NUM_CHAN=4, distinct gains per channel, 6-beat packet with tlast -> o_chan 0,1,2,3,0,1; next packet starts at 0.
//  5. Gain write mid-packet -> current packet keeps old gain; next packet uses new gain. Write coinciding with first beat -> deferred one packet.
//  6. Random o_tready toggling and input bubbles -> no loss or duplication, o_* stable while stalled; reset_n=0 mid-packet -> o_tvalid=0 next clk, sat_count=0, o_chan=0.

Source files
------------

// File: rtl/axi_magphase_gain_multi_if.sv
// Streaming beat bundle for the mag/phase gain stage: data, end-of-packet,
// and the valid/ready pair. Master drives data/last/valid, slave drives ready.
interface axi_magphase_gain_multi_if #(
  parameter int DW = 32
);
  logic [DW-1:0] tdata;
  logic          tlast;
  logic          tvalid;
  logic          tready;

  modport master (
    output tdata,
    output tlast,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tlast,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/axi_magphase_gain_multi.sv
// Multi-channel mag/phase gain stage. Input beats are TDM channels; each
// channel has its own magnitude gain, phase gain and phase offset. Magnitude
// is rounded and saturated, phase is rounded, offset and wrapped. Settings
// are latched into shadow registers on the first beat of every packet, so a
// packet is always processed with one consistent set of coefficients.
//
// Handshake: a beat moves across an interface on a clock edge where both
// tvalid and tready are high. tvalid never waits on tready, and while
// tvalid=1 and tready=0 the driver holds tdata/tlast stable. Here the whole
// pipeline shares one enable en = ~o_tvalid | o_tready, which is also
// i_tready, so bubbles travel as valid=0 and nothing combinational runs from
// i_tvalid to o_tvalid.
module axi_magphase_gain_multi #(
  parameter int WIDTH      = 16,
  parameter int GAIN_WIDTH = 16,
  parameter int GAIN_FRAC  = 14,
  parameter int NUM_CHAN   = 4,
  parameter int SR_BASE    = 192,
  localparam int CW        = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        set_stb,
  input  logic [7:0]                  set_addr,
  input  logic [31:0]                 set_data,
  axi_magphase_gain_multi_if.slave    i_axis,
  axi_magphase_gain_multi_if.master   o_axis,
  output logic [CW-1:0]               o_chan,
  output logic [15:0]                 sat_count
);

  localparam int PW        = WIDTH + GAIN_WIDTH;
  localparam int CTRL_ADDR = SR_BASE + 2 * NUM_CHAN;

  localparam logic signed [GAIN_WIDTH-1:0] UNITY = GAIN_WIDTH'(1) << GAIN_FRAC;
  localparam logic signed [PW:0]           HALF  = (PW+1)'(1) << (GAIN_FRAC - 1);
  localparam logic signed [PW:0]           MAXV  = ((PW+1)'(1) << (WIDTH - 1)) - (PW+1)'(1);
  localparam logic signed [PW:0]           MINV  = ~MAXV;

  // Live settings, written from the settings bus
  logic signed [GAIN_WIDTH-1:0] mag_gain   [NUM_CHAN];
  logic signed [GAIN_WIDTH-1:0] phase_gain [NUM_CHAN];
  logic signed [WIDTH-1:0]      phase_off  [NUM_CHAN];
  logic                         bypass;

  // Shadow settings, the only values the datapath uses mid-packet
  logic signed [GAIN_WIDTH-1:0] sh_mag_gain   [NUM_CHAN];
  logic signed [GAIN_WIDTH-1:0] sh_phase_gain [NUM_CHAN];
  logic signed [WIDTH-1:0]      sh_phase_off  [NUM_CHAN];
  logic                         sh_bypass;

  logic          first_beat;
  logic [CW-1:0] chan_cnt;
  logic          en;
  logic          accept;
  logic          sat_clr;

  assign en            = ~o_axis.tvalid | o_axis.tready;
  assign i_axis.tready = en;
  assign accept        = en & i_axis.tvalid;
  assign sat_clr       = set_stb && (set_addr == 8'(CTRL_ADDR)) && set_data[1];

  // Settings bus decode into the live registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CHAN; c++) begin
        mag_gain[c]   <= UNITY;
        phase_gain[c] <= UNITY;
        phase_off[c]  <= '0;
      end
      bypass <= 1'b0;
    end else if (set_stb) begin
      for (int c = 0; c < NUM_CHAN; c++) begin
        if (set_addr == 8'(SR_BASE + 2 * c))
          mag_gain[c] <= set_data[GAIN_WIDTH-1:0];
        if (set_addr == 8'(SR_BASE + 2 * c + 1)) begin
          phase_gain[c] <= GAIN_WIDTH'($signed(set_data[15:0]));
          phase_off[c]  <= WIDTH'($signed(set_data[31:16]));
        end
      end
      if (set_addr == 8'(CTRL_ADDR))
        bypass <= set_data[0];
    end
  end

  // Channel counter, packet-start tracking and shadow capture
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      chan_cnt   <= '0;
      first_beat <= 1'b1;
      for (int c = 0; c < NUM_CHAN; c++) begin
        sh_mag_gain[c]   <= UNITY;
        sh_phase_gain[c] <= UNITY;
        sh_phase_off[c]  <= '0;
      end
      sh_bypass <= 1'b0;
    end else if (accept) begin
      if (first_beat) begin
        for (int c = 0; c < NUM_CHAN; c++) begin
          sh_mag_gain[c]   <= mag_gain[c];
          sh_phase_gain[c] <= phase_gain[c];
          sh_phase_off[c]  <= phase_off[c];
        end
        sh_bypass <= bypass;
      end
      first_beat <= i_axis.tlast;
      if (i_axis.tlast || chan_cnt == CW'(NUM_CHAN - 1))
        chan_cnt <= '0;
      else
        chan_cnt <= chan_cnt + CW'(1);
    end
  end

  // Coefficients for the beat at the input: the first beat of a packet sees
  // the values being captured this cycle, later beats see the shadows.
  logic signed [GAIN_WIDTH-1:0] cur_mag_gain;
  logic signed [GAIN_WIDTH-1:0] cur_phase_gain;
  logic signed [WIDTH-1:0]      cur_phase_off;
  logic                         cur_bypass;

  // Select live or shadow coefficients for the current channel
  always_comb begin
    cur_mag_gain   = sh_mag_gain[chan_cnt];
    cur_phase_gain = sh_phase_gain[chan_cnt];
    cur_phase_off  = sh_phase_off[chan_cnt];
    cur_bypass     = sh_bypass;
    if (first_beat) begin
      cur_mag_gain   = mag_gain[chan_cnt];
      cur_phase_gain = phase_gain[chan_cnt];
      cur_phase_off  = phase_off[chan_cnt];
      cur_bypass     = bypass;
    end
  end

  logic signed [WIDTH-1:0] in_mag;
  logic signed [WIDTH-1:0] in_ph;
  logic signed [PW-1:0]    mag_prod;
  logic signed [PW-1:0]    ph_prod;

  assign in_mag   = i_axis.tdata[2*WIDTH-1:WIDTH];
  assign in_ph    = i_axis.tdata[WIDTH-1:0];
  assign mag_prod = $signed({{GAIN_WIDTH{in_mag[WIDTH-1]}}, in_mag})
                  * $signed({{WIDTH{cur_mag_gain[GAIN_WIDTH-1]}}, cur_mag_gain});
  assign ph_prod  = $signed({{GAIN_WIDTH{in_ph[WIDTH-1]}}, in_ph})
                  * $signed({{WIDTH{cur_phase_gain[GAIN_WIDTH-1]}}, cur_phase_gain});

  // Stage 1 registers: full-precision products plus beat side-band
  logic                    s1_valid;
  logic signed [PW-1:0]    s1_mag_prod;
  logic signed [PW-1:0]    s1_ph_prod;
  logic signed [WIDTH-1:0] s1_off;
  logic [2*WIDTH-1:0]      s1_raw;
  logic                    s1_last;
  logic [CW-1:0]           s1_chan;
  logic                    s1_bypass;

  // Stage 1: capture products and side-band
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid    <= 1'b0;
      s1_mag_prod <= '0;
      s1_ph_prod  <= '0;
      s1_off      <= '0;
      s1_raw      <= '0;
      s1_last     <= 1'b0;
      s1_chan     <= '0;
      s1_bypass   <= 1'b0;
    end else if (en) begin
      s1_valid    <= i_axis.tvalid;
      s1_mag_prod <= mag_prod;
      s1_ph_prod  <= ph_prod;
      s1_off      <= cur_phase_off;
      s1_raw      <= i_axis.tdata;
      s1_last     <= i_axis.tlast;
      s1_chan     <= chan_cnt;
      s1_bypass   <= cur_bypass;
    end
  end

  // Round half-up: add half an LSB of the output, then arithmetic shift.
  // One extra bit of headroom keeps the rounding add from overflowing.
  logic signed [PW:0] mag_sum;
  logic signed [PW:0] mag_rnd;
  logic signed [PW:0] ph_sum;

  assign mag_sum = {s1_mag_prod[PW-1], s1_mag_prod} + HALF;
  assign mag_rnd = mag_sum >>> GAIN_FRAC;
  assign ph_sum  = {s1_ph_prod[PW-1], s1_ph_prod} + HALF;

  // Stage 2 registers: rounded magnitude (unsaturated), wrapped phase
  logic                    s2_valid;
  logic signed [PW:0]      s2_mag;
  logic [WIDTH-1:0]        s2_ph;
  logic [2*WIDTH-1:0]      s2_raw;
  logic                    s2_last;
  logic [CW-1:0]           s2_chan;
  logic                    s2_bypass;

  // Stage 2: rounding and phase offset; phase wraps modulo 2^WIDTH
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s2_valid  <= 1'b0;
      s2_mag    <= '0;
      s2_ph     <= '0;
      s2_raw    <= '0;
      s2_last   <= 1'b0;
      s2_chan   <= '0;
      s2_bypass <= 1'b0;
    end else if (en) begin
      s2_valid  <= s1_valid;
      s2_mag    <= mag_rnd;
      s2_ph     <= WIDTH'(ph_sum >>> GAIN_FRAC) + s1_off;
      s2_raw    <= s1_raw;
      s2_last   <= s1_last;
      s2_chan   <= s1_chan;
      s2_bypass <= s1_bypass;
    end
  end

  logic [WIDTH-1:0] mag_sat;
  logic             sat_hit;

  // Clamp the rounded magnitude to the signed WIDTH-bit range
  always_comb begin
    mag_sat = s2_mag[WIDTH-1:0];
    sat_hit = 1'b0;
    if (s2_mag > MAXV) begin
      mag_sat = MAXV[WIDTH-1:0];
      sat_hit = 1'b1;
    end else if (s2_mag < MINV) begin
      mag_sat = MINV[WIDTH-1:0];
      sat_hit = 1'b1;
    end
  end

  logic out_sat;

  // Stage 3: output registers, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      o_axis.tvalid <= 1'b0;
      o_axis.tdata  <= '0;
      o_axis.tlast  <= 1'b0;
      o_chan        <= '0;
      out_sat       <= 1'b0;
    end else if (en) begin
      o_axis.tvalid <= s2_valid;
      o_axis.tdata  <= s2_bypass ? s2_raw : {mag_sat, s2_ph};
      o_axis.tlast  <= s2_last;
      o_chan        <= s2_chan;
      out_sat       <= s2_valid & ~s2_bypass & sat_hit;
    end
  end

  // Saturation counter: counts delivered saturated beats, sticks at all-ones
  always_ff @(posedge clk) begin
    if (!reset_n || sat_clr)
      sat_count <= '0;
    else if (o_axis.tvalid && o_axis.tready && out_sat && sat_count != 16'hFFFF)
      sat_count <= sat_count + 16'd1;
  end

endmodule

// File: tb/tb_axi_magphase_gain_multi.sv
module tb_axi_magphase_gain_multi;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [1:0]  o_chan;
  logic [15:0] sat_count;

  axi_magphase_gain_multi_if #(.DW(32)) in_if ();
  axi_magphase_gain_multi_if #(.DW(32)) out_if ();

  axi_magphase_gain_multi dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .set_stb   (set_stb),
    .set_addr  (set_addr),
    .set_data  (set_data),
    .i_axis    (in_if),
    .o_axis    (out_if),
    .o_chan    (o_chan),
    .sat_count (sat_count)
  );

  // ---------------- scoreboard state ----------------
  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  logic [34:0] exp_q[$];
  logic [34:0] obs_q[$];
  bit rand_rdy = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [34:0] ent(input bit last, input int chan, input int mag, input int ph);
    return {last, 2'(chan), 16'(mag), 16'(ph)};
  endfunction

  // Consumer ready: always high unless random back-pressure is enabled
  always @(posedge clk) begin
    #2;
    out_if.tready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Output monitor: capture handshakes and verify stability during stalls
  logic [34:0] mon_prev;
  bit          mon_stall = 1'b0;
  always @(negedge clk) begin
    logic [34:0] cur;
    cur = {out_if.tlast, o_chan, out_if.tdata};
    if (mon_stall && reset_n)
      check("stall_hold", {out_if.tvalid, cur}, {1'b1, mon_prev});
    if (out_if.tvalid === 1'b1 && out_if.tready === 1'b1)
      obs_q.push_back(cur);
    mon_stall = reset_n && (out_if.tvalid === 1'b1) && (out_if.tready === 1'b0);
    mon_prev  = cur;
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    in_if.tvalid = 1'b0;
    in_if.tlast  = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic write_reg(input int addr, input logic [31:0] data);
    set_stb  = 1'b1;
    set_addr = 8'(addr);
    set_data = data;
    @(posedge clk); #1;
    set_stb  = 1'b0;
  endtask

  // Presents a beat and returns just after the edge that accepted it,
  // with tvalid still high: the caller sends the next beat or idles.
  task automatic send_beat(input int mag, input int ph, input bit last);
    bit acc;
    int n;
    in_if.tdata  = {16'(mag), 16'(ph)};
    in_if.tlast  = last;
    in_if.tvalid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_if.tready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check(tag, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
    exp_q.delete();
    obs_q.delete();
  endtask

  int t6_mag[4] = '{1500, 500, 1500, -1000};
  int t6_off[4] = '{0, 100, 0, 0};

  // ---------------- directed sequence ----------------
  initial begin
    reset_n      = 1'b0;
    set_stb      = 1'b0;
    set_addr     = '0;
    set_data     = '0;
    in_if.tdata  = '0;
    in_if.tlast  = 1'b0;
    in_if.tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 64'(out_if.tvalid), 64'd0);
    check("rst_tdata",  64'(out_if.tdata),  64'd0);
    check("rst_tlast",  64'(out_if.tlast),  64'd0);
    check("rst_chan",   64'(o_chan),        64'd0);
    check("rst_sat",    64'(sat_count),     64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("rdy_after_rst", 64'(in_if.tready), 64'd1);

    // Defaults are unity gain, zero offset; check exact latency
    send_beat(1000, -500, 1'b1);
    in_if.tvalid = 1'b0;
    check("lat_s1", 64'(out_if.tvalid), 64'd0);
    @(posedge clk); #1;
    check("lat_s2", 64'(out_if.tvalid), 64'd0);
    @(posedge clk); #1;
    check("lat_s3_valid", 64'(out_if.tvalid), 64'd1);
    check("t1_data", 64'(out_if.tdata), 64'h03E8_FE0C);
    check("t1_last", 64'(out_if.tlast), 64'd1);
    check("t1_chan", 64'(o_chan), 64'd0);
    idle(3);
    obs_q.delete();

    // Magnitude gain 1.5, positive saturation
    write_reg(192, 32'h6000);
    send_beat(1000, 123, 1'b1);
    send_beat(30000, 123, 1'b1);
    idle(0);
    exp_q.push_back(ent(1, 0, 1500, 123));
    exp_q.push_back(ent(1, 0, 32767, 123));
    drain("t2a");
    check("t2a_sat", 64'(sat_count), 64'd1);

    // Gain 0.5, round half-up on both signs
    write_reg(192, 32'h2000);
    send_beat(3, 123, 1'b1);
    send_beat(-3, 123, 1'b1);
    idle(0);
    exp_q.push_back(ent(1, 0, 2, 123));
    exp_q.push_back(ent(1, 0, -1, 123));
    drain("t2b");
    check("t2b_sat", 64'(sat_count), 64'd1);

    // Phase offset wraps modulo 2^16
    write_reg(193, {16'd20000, 16'h4000});
    send_beat(1000, 20000, 1'b1);
    idle(0);
    exp_q.push_back(ent(1, 0, 500, 40000));
    drain("t3a");
    check("t3a_sat", 64'(sat_count), 64'd1);

    // Negative saturation at the lower bound
    write_reg(192, 32'h7FFF);
    send_beat(-32768, 0, 1'b1);
    idle(0);
    exp_q.push_back(ent(1, 0, -32768, 20000));
    drain("t3b");
    check("t3b_sat", 64'(sat_count), 64'd2);

    // Bypass passes raw data and leaves sat_count alone
    write_reg(200, 32'h1);
    send_beat(30000, 555, 1'b1);
    idle(0);
    exp_q.push_back(ent(1, 0, 30000, 555));
    drain("byp");
    check("byp_sat", 64'(sat_count), 64'd2);
    write_reg(200, 32'h2);
    check("sat_clear", 64'(sat_count), 64'd0);

    // Four channels, distinct gains, 6-beat packet then a new packet
    write_reg(192, 32'h4000);
    write_reg(193, 32'h0000_4000);
    write_reg(194, 32'h2000);
    write_reg(195, {16'd100, 16'h4000});
    write_reg(196, 32'h6000);
    write_reg(198, 32'hC000);
    for (int k = 0; k < 6; k++) send_beat(1000, 10 * k, k == 5);
    send_beat(1000, 60, 1'b1);
    idle(0);
    exp_q.push_back(ent(0, 0, 1000, 0));
    exp_q.push_back(ent(0, 1, 500, 110));
    exp_q.push_back(ent(0, 2, 1500, 20));
    exp_q.push_back(ent(0, 3, -1000, 30));
    exp_q.push_back(ent(0, 0, 1000, 40));
    exp_q.push_back(ent(1, 1, 500, 150));
    exp_q.push_back(ent(1, 0, 1000, 60));
    drain("t4");

    // Mid-packet write waits for the next packet
    for (int k = 0; k < 4; k++) send_beat(1000, 0, 1'b0);
    idle(0);
    write_reg(192, 32'h2000);
    send_beat(1000, 0, 1'b1);
    send_beat(1000, 0, 1'b1);
    // Write landing on the same edge as a first beat is deferred a packet
    set_stb  = 1'b1;
    set_addr = 8'd192;
    set_data = 32'h6000;
    send_beat(1000, 0, 1'b1);
    set_stb  = 1'b0;
    send_beat(1000, 0, 1'b1);
    idle(0);
    exp_q.push_back(ent(0, 0, 1000, 0));
    exp_q.push_back(ent(0, 1, 500, 100));
    exp_q.push_back(ent(0, 2, 1500, 0));
    exp_q.push_back(ent(0, 3, -1000, 0));
    exp_q.push_back(ent(1, 0, 1000, 0));
    exp_q.push_back(ent(1, 0, 500, 0));
    exp_q.push_back(ent(1, 0, 500, 0));
    exp_q.push_back(ent(1, 0, 1500, 0));
    drain("t5");

    // Random back-pressure and input bubbles
    rand_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      send_beat(1000, 7 * k, k == 7);
      idle($urandom_range(0, 2));
      exp_q.push_back(ent(k == 7, k % 4, t6_mag[k % 4], 7 * k + t6_off[k % 4]));
    end
    rand_rdy = 1'b0;
    drain("t6");

    // Reset in the middle of a packet with a beat in flight
    send_beat(30000, 0, 1'b0);
    send_beat(1000, 0, 1'b0);
    idle(0);
    exp_q.push_back(ent(0, 0, 32767, 0));
    exp_q.push_back(ent(0, 1, 500, 100));
    drain("t7a");
    check("t7a_sat", 64'(sat_count), 64'd1);
    send_beat(1000, 0, 1'b0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("t7_rst_tvalid", 64'(out_if.tvalid), 64'd0);
    check("t7_rst_sat",    64'(sat_count),     64'd0);
    check("t7_rst_chan",   64'(o_chan),        64'd0);
    check("t7_rst_tdata",  64'(out_if.tdata),  64'd0);
    in_if.tvalid = 1'b0;
    reset_n = 1'b1;
    idle(5);
    check("t7_no_residue", 64'(obs_q.size()), 64'd0);
    obs_q.delete();
    send_beat(1000, 7, 1'b1);
    send_beat(1000, 8, 1'b0);
    send_beat(1000, 9, 1'b1);
    idle(0);
    exp_q.push_back(ent(1, 0, 1000, 7));
    exp_q.push_back(ent(0, 0, 1000, 8));
    exp_q.push_back(ent(1, 1, 1000, 9));
    drain("t7c");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
